// File: rtl/pw_boot_loader.sv
// Program loader: takes a framed image (LEN_HI, LEN_LO, data, CHK) from a byte stream, writes it to RAM, then hands the bus to the CPU.
// Latency: a data byte accepted at edge n is written during cycle n+1; CPUEn/Error rise the cycle after CHK is accepted; the RUN bus path is combinational.
// Backpressure: RxReady is high while loading (one byte per cycle), and low in RUN, in ERR and until the first edge after reset release.
module pw_boot_loader #(
    parameter logic [15:0] LOAD_BASE = 16'h0000
) (
    input  logic        Clk,
    input  logic        RstN,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic        RxReady,
    input  logic [15:0] CpuAdr,
    input  logic [7:0]  CpuData,
    input  logic        CpuLd,
    input  logic        CpuWrt,
    output logic        CPUEn,
    output logic [15:0] MemAdr,
    output logic [7:0]  MemWData,
    output logic        MemWe,
    output logic        MemRe,
    output logic        Busy,
    output logic        Error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHK,
        RUN,
        ERR
    } state_t;

    // One registered RAM write; cleared to zero whenever no write is pending.
    typedef struct packed {
        logic [15:0] adr;
        logic [7:0]  dat;
    } wrReq_t;

    state_t      state;
    state_t      stateNext;
    logic        loadRdy;
    logic        readyEn;
    logic        xfer;
    logic [7:0]  lenHi;
    logic [15:0] byteCnt;
    logic [15:0] wrAdr;
    logic [7:0]  acc;
    logic        wrPend;
    wrReq_t      wrReq;

    assign RxReady = loadRdy & readyEn;
    assign xfer    = RxValid & RxReady;

    // Next-state logic and per-state stream readiness.
    always_comb begin
        stateNext = state;
        loadRdy   = 1'b0;
        case (state)
            IDLE: begin
                loadRdy = 1'b1;
                if (xfer) stateNext = LEN;
            end
            LEN: begin
                loadRdy = 1'b1;
                if (xfer) stateNext = ({lenHi, RxData} == 16'd0) ? CHK : DATA;
            end
            DATA: begin
                loadRdy = 1'b1;
                if (xfer && byteCnt == 16'd1) stateNext = CHK;
            end
            CHK: begin
                loadRdy = 1'b1;
                if (xfer) stateNext = (RxData == acc) ? RUN : ERR;
            end
            RUN:     stateNext = RUN;
            ERR:     stateNext = ERR;
            default: stateNext = IDLE;
        endcase
    end

    // State register; readyEn holds RxReady low until the first edge after reset release.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state   <= IDLE;
            readyEn <= 1'b0;
        end else begin
            state   <= stateNext;
            readyEn <= 1'b1;
        end
    end

    // Frame datapath: length capture, byte counter, write address and running checksum.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            lenHi   <= 8'h00;
            byteCnt <= 16'h0000;
            wrAdr   <= 16'h0000;
            acc     <= 8'h00;
        end else if (xfer) begin
            case (state)
                IDLE: lenHi <= RxData;
                LEN: begin
                    byteCnt <= {lenHi, RxData};
                    wrAdr   <= LOAD_BASE;
                    acc     <= 8'h00;
                end
                DATA: begin
                    byteCnt <= byteCnt - 16'd1;
                    wrAdr   <= wrAdr + 16'd1;
                    acc     <= acc + RxData;
                end
                default: ;
            endcase
        end
    end

    // Write register: each accepted data byte becomes exactly one MemWe cycle on the next cycle.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            wrPend <= 1'b0;
            wrReq  <= '0;
        end else if (xfer && state == DATA) begin
            wrPend    <= 1'b1;
            wrReq.adr <= wrAdr;
            wrReq.dat <= RxData;
        end else begin
            wrPend <= 1'b0;
            wrReq  <= '0;
        end
    end

    // Bus ownership: CPU passes straight through in RUN, otherwise the loader's write register drives RAM.
    always_comb begin
        MemAdr   = wrReq.adr;
        MemWData = wrReq.dat;
        MemWe    = wrPend;
        MemRe    = 1'b0;
        if (state == RUN) begin
            MemAdr   = CpuAdr;
            MemWData = CpuData;
            MemWe    = CpuWrt;
            MemRe    = CpuLd;
        end
    end

    assign CPUEn = (state == RUN);
    assign Error = (state == ERR);
    assign Busy  = (state == LEN) || (state == DATA) || (state == CHK) ||
                   ((state == IDLE) && wrPend);

endmodule

// File: tb/tb_pw_boot_loader.sv
// Bench for pw_boot_loader: two instances (LOAD_BASE 0 and 16'hFFFE) share one stream.
// Expected RAM writes are queued when bytes are issued; a negedge monitor pops and compares them.
// Status outputs are checked directly at the points of interest.
module tb_pw_boot_loader;

    logic        Clk = 1'b0;
    logic        RstN;
    logic [7:0]  RxData;
    logic        RxValid;
    logic [15:0] CpuAdr;
    logic [7:0]  CpuData;
    logic        CpuLd;
    logic        CpuWrt;

    logic        rxReady0, cpuEn0, memWe0, memRe0, busy0, error0;
    logic [15:0] memAdr0;
    logic [7:0]  memWData0;
    logic        rxReady1, cpuEn1, memWe1, memRe1, busy1, error1;
    logic [15:0] memAdr1;
    logic [7:0]  memWData1;

    always #5 Clk = ~Clk;

    pw_boot_loader #(.LOAD_BASE(16'h0000)) dut0 (
        .Clk(Clk), .RstN(RstN), .RxData(RxData), .RxValid(RxValid), .RxReady(rxReady0),
        .CpuAdr(CpuAdr), .CpuData(CpuData), .CpuLd(CpuLd), .CpuWrt(CpuWrt),
        .CPUEn(cpuEn0), .MemAdr(memAdr0), .MemWData(memWData0), .MemWe(memWe0),
        .MemRe(memRe0), .Busy(busy0), .Error(error0)
    );

    pw_boot_loader #(.LOAD_BASE(16'hFFFE)) dut1 (
        .Clk(Clk), .RstN(RstN), .RxData(RxData), .RxValid(RxValid), .RxReady(rxReady1),
        .CpuAdr(CpuAdr), .CpuData(CpuData), .CpuLd(CpuLd), .CpuWrt(CpuWrt),
        .CPUEn(cpuEn1), .MemAdr(memAdr1), .MemWData(memWData1), .MemWe(memWe1),
        .MemRe(memRe1), .Busy(busy1), .Error(error1)
    );

    int nChecks = 0;
    int nPass   = 0;

    logic [23:0] expQ0[$];
    logic [23:0] expQ1[$];
    logic [7:0]  frame[$];
    int          run0    = 0;
    int          maxRun0 = 0;
    logic        preEn;
    logic        preBusy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act === req) nPass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic failNow(input string msg);
        nChecks++;
        $display("FAIL %s", msg);
    endtask

    // Scoreboard monitor: every loader-owned write must match the head of the expected queue.
    always @(negedge Clk) begin
        if (RstN) begin
            if (memWe0 && !cpuEn0) begin
                if (expQ0.size() == 0)
                    failNow($sformatf("dut0 write: got %h:%h, required none", memAdr0, memWData0));
                else
                    check("dut0 write", {8'h00, memAdr0, memWData0}, {8'h00, expQ0.pop_front()});
                run0++;
                if (run0 > maxRun0) maxRun0 = run0;
            end else begin
                run0 = 0;
            end
            if (memWe1 && !cpuEn1) begin
                if (expQ1.size() == 0)
                    failNow($sformatf("dut1 write: got %h:%h, required none", memAdr1, memWData1));
                else
                    check("dut1 write", {8'h00, memAdr1, memWData1}, {8'h00, expQ1.pop_front()});
            end
            if (!cpuEn0) check("dut0 MemRe while loader owns bus", {31'd0, memRe0}, 32'd0);
        end
    end

    task automatic sendByte(input logic [7:0] b);
        int waitCyc;
        waitCyc = 0;
        @(negedge Clk); #1;
        RxData  = b;
        RxValid = 1'b1;
        while (!(rxReady0 && rxReady1) && waitCyc < 50) begin
            @(negedge Clk); #1;
            waitCyc++;
        end
        if (waitCyc >= 50) begin
            failNow($sformatf("sendByte %h: RxReady stayed %b/%b, required 1", b, rxReady0, rxReady1));
            RxValid = 1'b0;
        end else begin
            @(posedge Clk); #1;
            RxValid = 1'b0;
            RxData  = 8'hEE;
        end
    endtask

    task automatic sendFrame(input bit throttle);
        int          len;
        logic [15:0] a0, a1;
        len = int'({frame[0], frame[1]});
        for (int i = 0; i < frame.size(); i++) begin
            if (i >= 2 && i < 2 + len) begin
                a0 = 16'h0000 + 16'(i - 2);
                a1 = 16'hFFFE + 16'(i - 2);
                expQ0.push_back({a0, frame[i]});
                expQ1.push_back({a1, frame[i]});
            end
            if (throttle) repeat ($urandom_range(0, 3)) @(negedge Clk);
            if (i == frame.size() - 1) begin
                preEn   = cpuEn0 | cpuEn1;
                preBusy = busy0 & busy1;
            end
            sendByte(frame[i]);
        end
    endtask

    task automatic checkResetState(input string tag);
        check({tag, " CPUEn0"},    {31'd0, cpuEn0},    32'd0);
        check({tag, " MemWe0"},    {31'd0, memWe0},    32'd0);
        check({tag, " MemRe0"},    {31'd0, memRe0},    32'd0);
        check({tag, " MemAdr0"},   {16'd0, memAdr0},   32'd0);
        check({tag, " MemWData0"}, {24'd0, memWData0}, 32'd0);
        check({tag, " Busy0"},     {31'd0, busy0},     32'd0);
        check({tag, " Error0"},    {31'd0, error0},    32'd0);
        check({tag, " CPUEn1"},    {31'd0, cpuEn1},    32'd0);
        check({tag, " MemWe1"},    {31'd0, memWe1},    32'd0);
        check({tag, " Busy1"},     {31'd0, busy1},     32'd0);
        check({tag, " Error1"},    {31'd0, error1},    32'd0);
    endtask

    task automatic doReset(input string tag);
        @(negedge Clk); #2;
        RstN = 1'b0;
        #1;
        checkResetState(tag);
        @(negedge Clk); #2;
        RstN = 1'b1;
        repeat (2) @(negedge Clk);
        #1;
        check({tag, " RxReady after release"}, {31'd0, rxReady0 & rxReady1}, 32'd1);
    endtask

    task automatic drainCheck(input string tag);
        repeat (3) @(negedge Clk);
        #1;
        check({tag, " writes outstanding dut0"}, expQ0.size(), 32'd0);
        check({tag, " writes outstanding dut1"}, expQ1.size(), 32'd0);
    endtask

    initial begin
        RstN    = 1'b0;
        RxValid = 1'b0;
        RxData  = 8'h00;
        CpuAdr  = 16'hBEEF;
        CpuData = 8'hC3;
        CpuLd   = 1'b1;
        CpuWrt  = 1'b1;
        #2;
        checkResetState("power-on");
        @(negedge Clk); #2;
        RstN = 1'b1;
        repeat (2) @(negedge Clk);
        #1;
        check("RxReady after power-on", {31'd0, rxReady0}, 32'd1);

        // Basic load, back-to-back bytes.
        maxRun0 = 0;
        frame = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        sendFrame(1'b0);
        check("basic CPUEn before CHK", {31'd0, preEn}, 32'd0);
        check("basic Busy before CHK", {31'd0, preBusy}, 32'd1);
        check("basic CPUEn0 after CHK", {31'd0, cpuEn0}, 32'd1);
        check("basic CPUEn1 after CHK", {31'd0, cpuEn1}, 32'd1);
        check("basic Busy after CHK", {31'd0, busy0}, 32'd0);
        check("basic RxReady in RUN", {31'd0, rxReady0}, 32'd0);
        drainCheck("basic");
        check("basic consecutive write cycles", maxRun0, 32'd3);

        // Bad checksum: AA+55 = FF, CHK 00.
        doReset("pre-badchk");
        frame = '{8'h00, 8'h02, 8'hAA, 8'h55, 8'h00};
        sendFrame(1'b0);
        check("badchk Error0", {31'd0, error0}, 32'd1);
        check("badchk Error1", {31'd0, error1}, 32'd1);
        check("badchk CPUEn0", {31'd0, cpuEn0}, 32'd0);
        check("badchk Busy0", {31'd0, busy0}, 32'd0);
        RxValid = 1'b1;
        RxData  = 8'h12;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk); #1;
            check("badchk RxReady in ERR", {31'd0, rxReady0 | rxReady1}, 32'd0);
        end
        RxValid = 1'b0;
        drainCheck("badchk");
        check("badchk Error sticky", {31'd0, error0}, 32'd1);

        // Zero length, then combinational pass-through.
        doReset("pre-zero");
        frame = '{8'h00, 8'h00, 8'h00};
        sendFrame(1'b0);
        check("zero CPUEn", {31'd0, cpuEn0 & cpuEn1}, 32'd1);
        drainCheck("zero");
        CpuAdr  = 16'h1234;
        CpuData = 8'h5A;
        CpuWrt  = 1'b1;
        CpuLd   = 1'b0;
        #1;
        check("pass MemAdr", {16'd0, memAdr0}, 32'h1234);
        check("pass MemWData", {24'd0, memWData0}, 32'h5A);
        check("pass MemWe", {31'd0, memWe0}, 32'd1);
        check("pass MemRe", {31'd0, memRe0}, 32'd0);
        check("pass MemAdr dut1", {16'd0, memAdr1}, 32'h1234);
        CpuWrt = 1'b0;
        CpuLd  = 1'b1;
        CpuAdr = 16'h00A7;
        #1;
        check("pass read MemRe", {31'd0, memRe0}, 32'd1);
        check("pass read MemWe", {31'd0, memWe0}, 32'd0);
        check("pass read MemAdr", {16'd0, memAdr0}, 32'h00A7);
        CpuAdr  = 16'hBEEF;
        CpuData = 8'hC3;
        CpuWrt  = 1'b1;

        // Wrap-around: dut1 writes FFFE:01, FFFF:02, 0000:03.
        doReset("pre-wrap");
        frame = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h06};
        sendFrame(1'b0);
        check("wrap CPUEn", {31'd0, cpuEn0 & cpuEn1}, 32'd1);
        check("wrap Error", {31'd0, error0 | error1}, 32'd0);
        drainCheck("wrap");

        // Throttled 16-byte frame 01..10, sum 0x88.
        doReset("pre-throttle");
        frame = '{8'h00, 8'h10};
        for (int k = 1; k <= 16; k++) frame.push_back(8'(k));
        frame.push_back(8'h88);
        sendFrame(1'b1);
        check("throttle CPUEn", {31'd0, cpuEn0 & cpuEn1}, 32'd1);
        check("throttle Error", {31'd0, error0 | error1}, 32'd0);
        drainCheck("throttle");

        // Reset mid-frame after 2 of 5 data bytes, then a fresh frame.
        doReset("pre-midreset");
        sendByte(8'h00);
        sendByte(8'h05);
        expQ0.push_back({16'h0000, 8'hA1});
        expQ1.push_back({16'hFFFE, 8'hA1});
        sendByte(8'hA1);
        expQ0.push_back({16'h0001, 8'hA2});
        expQ1.push_back({16'hFFFF, 8'hA2});
        sendByte(8'hA2);
        @(negedge Clk); #1;
        check("midreset Busy before reset", {31'd0, busy0}, 32'd1);
        check("midreset writes seen", expQ0.size() + expQ1.size(), 32'd0);
        doReset("midreset");
        frame = '{8'h00, 8'h02, 8'hC1, 8'hC2, 8'h83};
        sendFrame(1'b0);
        check("midreset reload CPUEn", {31'd0, cpuEn0 & cpuEn1}, 32'd1);
        check("midreset reload Error", {31'd0, error0 | error1}, 32'd0);
        drainCheck("midreset reload");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #500000;
        failNow("watchdog: bench did not complete within time limit");
        $display("%0d/%0d checks passed", nPass, nChecks);
        $fatal(1);
    end

endmodule
